// File: rtl/reflet_synth_sequencer_if.sv
// Note-push bus between a host or bus wrapper and the sequencer's note FIFO.
// master drives notes in; slave (the sequencer) reports whether it can take one.
interface reflet_synth_sequencer_if;
  logic       note_valid;
  logic       note_ready;
  logic [5:0] note_tone;
  logic [1:0] note_volume;
  logic [7:0] note_duration;

  modport master (
    output note_valid,
    output note_tone,
    output note_volume,
    output note_duration,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_tone,
    input  note_volume,
    input  note_duration,
    output note_ready
  );
endinterface

// File: rtl/reflet_synth_sequencer.sv
// Note sequencer feeding reflet_synth_generator: queues notes in a FIFO and plays
// each one for its duration, with an optional silent gap between notes.
module reflet_synth_sequencer #(
  parameter int clock_freq   = 1000000,
  parameter int time_unit_ms = 10,
  parameter int fifo_depth   = 8,
  parameter int gap_units    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         flush,
  reflet_synth_sequencer_if.slave      note,
  output logic [5:0]                   tone,
  output logic [1:0]                   volume,
  output logic                         playing,
  output logic [$clog2(fifo_depth):0]  fifo_count
);

  localparam int UNIT_CYCLES = (clock_freq / 1000) * time_unit_ms;
  localparam int PTR_W       = $clog2(fifo_depth);
  localparam int PRESC_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  typedef struct packed {
    logic [5:0] tone;
    logic [1:0] volume;
    logic [7:0] duration;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Note FIFO
  // ---------------------------------------------------------------------------
  note_t            mem [fifo_depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  note_t            head;

  assign full            = (count == (PTR_W + 1)'(fifo_depth));
  assign empty           = (count == '0);
  assign note.note_ready = !reset && !full && !flush;
  assign push            = note.note_valid && note.note_ready;
  assign head            = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone decide which
  // entries are live, so clearing the array would only cost flops and fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= note_t'({note.note_tone, note.note_volume, note.note_duration});
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: prescaler, unit counter and note/gap FSM
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [5:0]         tone_q, tone_d;
  logic [1:0]         vol_q, vol_d;
  logic [7:0]         rem_q, rem_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               active;
  logic               tick;
  logic               take_next;

  // Timers only run while a note or gap is being timed and the block is not paused.
  assign active = enable && (state_q != S_IDLE);
  assign tick   = active && (presc_q == PRESC_W'(UNIT_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tone_d    = tone_q;
    vol_d     = vol_q;
    rem_d     = rem_q;
    presc_d   = presc_q;
    pop       = 1'b0;
    take_next = 1'b0;

    if (active) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        take_next = enable && !empty;
      end
      S_PLAY: begin
        if (tick) begin
          if (rem_q == 8'd1) begin
            if (gap_units > 0) begin
              state_d = S_GAP;
              vol_d   = '0;
              rem_d   = 8'(gap_units);
              presc_d = '0;
            end else begin
              state_d   = S_IDLE;
              take_next = !empty;
            end
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (rem_q == 8'd1) begin
            state_d   = S_IDLE;
            take_next = !empty;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A zero-duration note is popped and dropped, leaving the FSM in IDLE.
    if (take_next) begin
      pop = 1'b1;
      if (head.duration != 8'd0) begin
        state_d = S_PLAY;
        tone_d  = head.tone;
        vol_d   = head.volume;
        rem_d   = head.duration;
        presc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tone_q  <= '0;
      vol_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      vol_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      vol_q   <= vol_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  // Pause silences the output immediately while the held note stays loaded.
  assign tone       = tone_q;
  assign playing    = (state_q == S_PLAY);
  assign volume     = (state_q == S_PLAY && enable) ? vol_q : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_reflet_synth_sequencer.sv
// Directed bench for reflet_synth_sequencer: one instance with a one-unit gap and
// one legato instance, both at 4 clocks per unit with a 4-deep FIFO.
module tb_reflet_synth_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic flush;

  reflet_synth_sequencer_if bus_a ();
  reflet_synth_sequencer_if bus_b ();

  logic [5:0] tone_a, tone_b;
  logic [1:0] vol_a, vol_b;
  logic       play_a, play_b;
  logic [2:0] cnt_a, cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reflet_synth_sequencer #(
    .clock_freq  (1000),
    .time_unit_ms(4),
    .fifo_depth  (4),
    .gap_units   (1)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .note      (bus_a),
    .tone      (tone_a),
    .volume    (vol_a),
    .playing   (play_a),
    .fifo_count(cnt_a)
  );

  reflet_synth_sequencer #(
    .clock_freq  (1000),
    .time_unit_ms(4),
    .fifo_depth  (4),
    .gap_units   (0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .note      (bus_b),
    .tone      (tone_b),
    .volume    (vol_b),
    .playing   (play_b),
    .fifo_count(cnt_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both instances see identical stimulus on their note buses.
  task automatic set_note(input logic v, input logic [5:0] t, input logic [1:0] vo,
                          input logic [7:0] d);
    bus_a.note_valid    = v;
    bus_a.note_tone     = t;
    bus_a.note_volume   = vo;
    bus_a.note_duration = d;
    bus_b.note_valid    = v;
    bus_b.note_tone     = t;
    bus_b.note_volume   = vo;
    bus_b.note_duration = d;
  endtask

  task automatic push(input logic [5:0] t, input logic [1:0] vo, input logic [7:0] d);
    set_note(1'b1, t, vo, d);
    step();
    set_note(1'b0, 6'd0, 2'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    flush  = 1'b0;
    set_note(1'b0, 6'd0, 2'd0, 8'd0);
    step();
    step();
    check("ready_in_reset", int'(bus_a.note_ready), 0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int seen_one;
    int hits;

    // Reset state and a single note with a one-unit gap.
    do_reset();
    check("rst_ready",   int'(bus_a.note_ready), 1);
    check("rst_count",   int'(cnt_a), 0);
    check("rst_tone",    int'(tone_a), 0);
    check("rst_volume",  int'(vol_a), 0);
    check("rst_playing", int'(play_a), 0);
    push(6'd32, 2'd3, 8'd2);
    check("latency_pre_load_vol", int'(vol_a), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      check("single_tone",    int'(tone_a), 32);
      check("single_vol",     int'(vol_a), 3);
      check("single_playing", int'(play_a), 1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("gap_vol",     int'(vol_a), 0);
      check("gap_playing", int'(play_a), 0);
      step();
    end
    check("idle_count",     int'(cnt_a), 0);
    check("idle_vol",       int'(vol_a), 0);
    check("idle_tone_hold", int'(tone_a), 32);

    // Legato back-to-back notes: no silent cycle between them.
    do_reset();
    push(6'd5, 2'd2, 8'd1);
    push(6'd6, 2'd1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      check("legato1_tone", int'(tone_b), 5);
      check("legato1_vol",  int'(vol_b), 2);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("legato2_tone", int'(tone_b), 6);
      check("legato2_vol",  int'(vol_b), 1);
      step();
    end
    check("legato_end_vol",     int'(vol_b), 0);
    check("legato_end_playing", int'(play_b), 0);

    // Fill the FIFO while paused, overflow attempt, then play in order.
    do_reset();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", int'(bus_b.note_ready), 1);
      push(6'(10 + k), 2'd1, 8'd1);
    end
    check("full_ready", int'(bus_b.note_ready), 0);
    check("full_count", int'(cnt_b), 4);
    check("paused_vol", int'(vol_b), 0);
    push(6'd14, 2'd1, 8'd1);
    check("overflow_count", int'(cnt_b), 4);
    enable = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      check("order_tone", int'(tone_b), 10 + k);
      check("order_vol",  int'(vol_b), 1);
      repeat (4) step();
    end
    check("order_done_vol",   int'(vol_b), 0);
    check("order_done_count", int'(cnt_b), 0);
    check("order_no_fifth",   int'(tone_b), 13);

    // Pause mid-note: audible time is unchanged by a 10-cycle pause.
    do_reset();
    push(6'd20, 2'd3, 8'd3);
    step();
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      enable = !(i >= 5 && i < 15);
      #1;
      if (vol_a == 2'd3) hits++;
      if (i == 10) begin
        check("pause_vol",     int'(vol_a), 0);
        check("pause_playing", int'(play_a), 1);
        check("pause_tone",    int'(tone_a), 20);
      end
      step();
    end
    enable = 1'b1;
    check("pause_total_cycles", hits, 12);

    // Zero-duration note is discarded; the next one plays normally.
    do_reset();
    push(6'd1, 2'd3, 8'd0);
    push(6'd2, 2'd3, 8'd1);
    seen_one = 0;
    hits     = 0;
    for (int i = 0; i < 12; i++) begin
      if (tone_a == 6'd1) seen_one = 1;
      if (tone_a == 6'd2 && vol_a == 2'd3) hits++;
      step();
    end
    check("discard_never_tone1", seen_one, 0);
    check("discard_next_cycles", hits, 4);

    // Flush mid-note with a queued note and a simultaneous write.
    do_reset();
    push(6'd7, 2'd2, 8'd4);
    push(6'd8, 2'd1, 8'd2);
    repeat (3) step();
    check("preflush_count",   int'(cnt_a), 1);
    check("preflush_playing", int'(play_a), 1);
    flush = 1'b1;
    set_note(1'b1, 6'd9, 2'd3, 8'd5);
    #1;
    check("flush_ready", int'(bus_a.note_ready), 0);
    step();
    flush = 1'b0;
    set_note(1'b0, 6'd0, 2'd0, 8'd0);
    check("flush_vol",     int'(vol_a), 0);
    check("flush_playing", int'(play_a), 0);
    check("flush_count",   int'(cnt_a), 0);
    repeat (6) step();
    check("flush_stays_silent", int'(vol_a), 0);
    check("flush_no_queue",     int'(cnt_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
